// File: rtl/dpram_rdout_streamer_pkg.sv
// Shared definitions for the DPRAM readout streamer: lane geometry, FSM states,
// and the length-to-64-bit-word conversion.
package dpram_rdout_streamer_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_FLUSH,
        ST_DONE,
        ST_HOLD
    } state_t;

    // Number of 64-bit RAM words holding len 16-bit words, rounded up.
    function automatic logic [16:0] words_for_len(input logic [15:0] len);
        return ({1'b0, len} + 17'd3) >> 2;
    endfunction

endpackage

// File: rtl/dpram_rdout_streamer_rdout_word_fifo.sv
// Synchronous 64-bit prefetch FIFO between the DPRAM read pipeline and the lane
// serializer; head word is visible combinationally on o_data.
module rdout_word_fifo
    import dpram_rdout_streamer_pkg::*;
#(
    parameter int P_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [WORD_W-1:0]         i_data,
    input  logic                      i_pop,
    output logic [WORD_W-1:0]         o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(P_DEPTH):0]  o_count
);

    localparam int AW = $clog2(P_DEPTH);

    logic [WORD_W-1:0] r_mem [P_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (AW+1)'(P_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dpram_rdout_streamer.sv
// Drains a filled double_buffer half as a 16-bit valid/ready stream: address issue
// with bounded prefetch, read-latency tracking, FIFO and lane serializer.
module dpram_rdout_streamer
    import dpram_rdout_streamer_pkg::*;
#(
    parameter int P_RD_ADR_WIDTH = 9,
    parameter int P_RD_LAT       = 1,
    parameter int P_FIFO_DEPTH   = 4,
    parameter int P_HOLDOFF      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      rd_busy,
    input  logic [15:0]               dpram_len,
    output logic [P_RD_ADR_WIDTH-1:0] rd_addr,
    input  logic [WORD_W-1:0]         rd_dout,
    output logic                      done,
    output logic [LANE_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      len_err,
    output logic [15:0]               n_bufs
);

    localparam int CAP = LANES << P_RD_ADR_WIDTH;
    localparam int CW  = $clog2(P_FIFO_DEPTH) + 1;

    state_t                    r_state, w_state_next;
    logic [1:0]                r_len_mod;
    logic [16:0]               r_words;
    logic                      r_len_ok;
    logic [16:0]               r_addr_cnt;
    logic [P_RD_ADR_WIDTH-1:0] r_rd_addr;
    logic [P_RD_LAT:0]         r_pipe;
    logic [7:0]                r_hold_cnt;
    logic [15:0]               r_n_bufs;

    logic [WORD_W-1:0]         r_word;
    logic [1:0]                r_lane;
    logic [1:0]                r_nlanes_m1;
    logic                      r_last_word;
    logic                      r_out_valid;
    logic [16:0]               r_pop_cnt;

    logic [WORD_W-1:0]         w_fifo_dout;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [CW-1:0]             w_fifo_count;
    logic [3:0]                w_inflight;
    logic                      w_room;
    logic                      w_issue;
    logic                      w_pop;
    logic                      w_hs;
    logic                      w_lane_end;
    logic [LANE_W-1:0]         w_lanes [LANES];

    // r_pipe[0] marks an address on rd_addr now; r_pipe[P_RD_LAT] marks rd_dout valid.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= P_RD_LAT; i++) begin
            w_inflight = w_inflight + {3'b0, r_pipe[i]};
        end
    end

    assign w_room  = ({{(8-CW){1'b0}}, w_fifo_count} + {4'b0, w_inflight}) < 8'(P_FIFO_DEPTH);
    // First address goes out on the CHECK->READ edge to meet first-word latency.
    assign w_issue = ((r_state == ST_CHECK && r_len_ok) || r_state == ST_READ)
                     && (r_addr_cnt < r_words) && w_room && !w_fifo_full;

    assign w_hs       = r_out_valid && out_ready;
    assign w_lane_end = (r_lane == r_nlanes_m1);
    assign w_pop      = !w_fifo_empty && (!r_out_valid || (w_hs && w_lane_end));

    rdout_word_fifo #(
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pipe[P_RD_LAT]),
        .i_data  (rd_dout),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (en && rd_busy) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = r_len_ok ? ST_READ : ST_DONE;
            ST_READ:  if (r_addr_cnt == r_words || (w_issue && (r_addr_cnt + 17'd1 == r_words)))
                          w_state_next = ST_FLUSH;
            ST_FLUSH: if (r_pipe == '0 && w_fifo_empty && !r_out_valid) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_HOLD;
            ST_HOLD:  if (r_hold_cnt == 8'(P_HOLDOFF - 1)) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len_mod  <= '0;
            r_words    <= '0;
            r_len_ok   <= 1'b0;
            r_addr_cnt <= '0;
            r_rd_addr  <= '0;
            r_pipe     <= '0;
            r_hold_cnt <= '0;
            r_n_bufs   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pipe  <= {r_pipe[P_RD_LAT-1:0], w_issue};
            if (r_state == ST_IDLE) begin
                r_len_mod  <= dpram_len[1:0];
                r_words    <= words_for_len(dpram_len);
                r_len_ok   <= (dpram_len != 16'd0) && ({1'b0, dpram_len} <= 17'(CAP));
                r_addr_cnt <= '0;
            end
            if (w_issue) begin
                r_rd_addr  <= r_addr_cnt[P_RD_ADR_WIDTH-1:0];
                r_addr_cnt <= r_addr_cnt + 17'd1;
            end
            if (r_state == ST_DONE) begin
                r_hold_cnt <= '0;
                if (r_len_ok) r_n_bufs <= r_n_bufs + 16'd1;
            end else if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    // Lane serializer: the last RAM word of a buffer may carry fewer than four lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_lane      <= '0;
            r_nlanes_m1 <= 2'd3;
            r_last_word <= 1'b0;
            r_out_valid <= 1'b0;
            r_pop_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE) r_pop_cnt <= '0;
            if (w_pop) begin
                r_word      <= w_fifo_dout;
                r_lane      <= '0;
                r_out_valid <= 1'b1;
                r_pop_cnt   <= r_pop_cnt + 17'd1;
                r_last_word <= (r_pop_cnt + 17'd1 == r_words);
                r_nlanes_m1 <= (r_pop_cnt + 17'd1 == r_words) ? (r_len_mod - 2'd1) : 2'd3;
            end else if (w_hs) begin
                if (w_lane_end) r_out_valid <= 1'b0;
                else            r_lane      <= r_lane + 2'd1;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lanes[gi] = r_word[gi*LANE_W +: LANE_W];
    end

    assign rd_addr   = r_rd_addr;
    assign done      = (r_state == ST_DONE);
    assign len_err   = (r_state == ST_CHECK) && !r_len_ok;
    assign out_data  = w_lanes[r_lane];
    assign out_valid = r_out_valid;
    assign out_last  = r_out_valid && r_last_word && w_lane_end;
    assign n_bufs    = r_n_bufs;

endmodule
